// File: rtl/fxp_accum_sequencer_pkg.sv
// Shared definitions for the fixed-point accumulate sequencer: default widths,
// state encoding and the default-width saturation limits.
package fxp_accum_sequencer_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_FRAC_W = 16;
    localparam int DEF_CNT_W  = 16;

    // State encoding kept as plain constants so older tools see a fixed 2-bit code.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [DEF_DATA_W-1:0] FXP_MAX = 32'h7FFF_FFFF;
    localparam logic [DEF_DATA_W-1:0] FXP_MIN = 32'h8000_0000;

endpackage

// File: rtl/fxp_addsub_unit.sv
// Combinational signed add/subtract step with overflow detect.
// Saturating clamp on overflow is built when FXP_SATURATE_EN is defined.
module fxp_addsub_unit #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);

    logic [DATA_W:0] wide_a_s;
    logic [DATA_W:0] wide_b_s;
    logic [DATA_W:0] wide_sum_s;

    assign wide_a_s = {a[DATA_W-1], a};
    assign wide_b_s = {b[DATA_W-1], b};

    // One extra bit of headroom makes the true sign visible in bit DATA_W.
    always_comb begin
        if (sub) begin
            wide_sum_s = wide_a_s - wide_b_s;
        end else begin
            wide_sum_s = wide_a_s + wide_b_s;
        end
    end

    assign overflow = wide_sum_s[DATA_W] ^ wide_sum_s[DATA_W-1];

`ifdef FXP_SATURATE_EN
    // Clamp toward the true sign of the wide result.
    always_comb begin
        if (overflow) begin
            if (wide_sum_s[DATA_W]) begin
                result = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                result = {1'b0, {(DATA_W-1){1'b1}}};
            end
        end else begin
            result = wide_sum_s[DATA_W-1:0];
        end
    end
`else
    assign result = wide_sum_s[DATA_W-1:0];
`endif

endmodule

// File: rtl/fxp_accum_sequencer.sv
// Accumulates a stream of signed fixed-point beats into one result per sequence
// with sticky overflow and a saturating beat count. Optional: FXP_SATURATE_EN.
module fxp_accum_sequencer
    import fxp_accum_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_op,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_overflow,
    output logic [CNT_W-1:0]  out_count
);

    // The binary point is notional; values pass through without rescaling.
    if (FRAC_W >= DATA_W) begin : g_bad_frac
        $error("FRAC_W must be smaller than DATA_W");
    end

    logic [1:0]        state_r;
    logic [1:0]        state_next_s;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] step_result_s;
    logic              step_ovf_s;
    logic              ovf_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              in_fire_s;
    logic              out_fire_s;

    assign in_ready     = (state_r != ST_DRAIN);
    assign out_valid    = (state_r == ST_DRAIN);
    assign in_fire_s    = in_valid & in_ready;
    assign out_fire_s   = out_valid & out_ready;
    assign out_data     = acc_r;
    assign out_overflow = ovf_r;
    assign out_count    = cnt_r;

    fxp_addsub_unit #(
        .DATA_W (DATA_W)
    ) u_addsub (
        .a        (acc_r),
        .b        (in_data),
        .sub      (in_op),
        .result   (step_result_s),
        .overflow (step_ovf_s)
    );

    // Sequence control: a beat tagged last moves straight to DRAIN from IDLE or ACCUM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_ACCUM: begin
                if (in_fire_s) begin
                    state_next_s = in_last ? ST_DRAIN : ST_ACCUM;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_DRAIN: begin
                if (out_fire_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath registers; clearing on the output handshake starts the next sequence at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {DATA_W{1'b0}};
            ovf_r <= 1'b0;
            cnt_r <= {CNT_W{1'b0}};
        end else if (out_fire_s) begin
            acc_r <= {DATA_W{1'b0}};
            ovf_r <= 1'b0;
            cnt_r <= {CNT_W{1'b0}};
        end else if (in_fire_s) begin
            acc_r <= step_result_s;
            ovf_r <= ovf_r | step_ovf_s;
            if (cnt_r != {CNT_W{1'b1}}) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            acc_r <= acc_r;
            ovf_r <= ovf_r;
            cnt_r <= cnt_r;
        end
    end

endmodule
